uart_receiver: RTL and testbench

- Serial-to-parallel UART receiver. It is the receive-side companion of uart_transmitter and decodes the frames that block produces.
- Frame format is 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1). The idle line is high.
- The block samples each bit at mid-bit, using a per-bit clock counter on the single system clock.
- It delivers each received byte with a one-cycle data_ready pulse and flags bad stop bits.

---
 rtl/uart_receiver_pkg.sv | 16 +
 rtl/uart_bit_sync.sv | 27 ++
 rtl/uart_receiver.sv | 133 +++++++++++++
 tb/tb_uart_receiver.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_receiver_pkg.sv
// Shared types and constants for the UART receive path.
package uart_receiver_pkg;

  typedef logic       bit_t;
  typedef logic [7:0] uint8_t;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchronizer for a single asynchronous bit; resets to 1 (idle line level).
module uart_bit_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q, sync_d;

  // Shift the raw input through two stages.
  always_comb begin
    sync_d = {sync_q[0], d_i};
  end

  // Synchronizer flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: detects the start edge, samples each bit at mid-bit and
// reports either a received byte or a bad stop bit with a one-cycle pulse.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_input_rx,
  output logic [7:0] received_data,
  output logic       data_ready,
  output logic       framing_error,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LastBit = 3'(UART_DATA_BITS - 1);

  bit_t rx_s;
  bit_t rx_prev_q, rx_prev_d;

  rx_state_t state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  uint8_t shift_q, shift_d;
  uint8_t data_q, data_d;
  logic data_ready_q, data_ready_d;
  logic framing_error_q, framing_error_d;

  uart_bit_sync u_sync (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   (serial_input_rx),
    .q_o   (rx_s)
  );

  // Next-state logic: frame sequencing, bit sampling and result pulses.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    bit_idx_d       = bit_idx_q;
    shift_d         = shift_q;
    data_d          = data_q;
    data_ready_d    = 1'b0;
    framing_error_d = 1'b0;
    rx_prev_d       = rx_s;

    unique case (state_q)
      IDLE: begin
        // Needs a fresh 1->0 edge, so a held-low line never starts a frame.
        if (rx_prev_q && !rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CntFull) begin
          // LSB arrives first, so shift in from the top.
          shift_d   = {rx_s, shift_q[7:1]};
          cnt_d     = '0;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LastBit) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CntFull) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (rx_s) begin
            data_d       = shift_q;
            data_ready_d = 1'b1;
          end else begin
            framing_error_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      bit_idx_q       <= '0;
      shift_q         <= '0;
      data_q          <= '0;
      data_ready_q    <= 1'b0;
      framing_error_q <= 1'b0;
      rx_prev_q       <= 1'b1;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      data_q          <= data_d;
      data_ready_q    <= data_ready_d;
      framing_error_q <= framing_error_d;
      rx_prev_q       <= rx_prev_d;
    end
  end

  assign received_data = data_q;
  assign data_ready    = data_ready_q;
  assign framing_error = framing_error_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: the driver serialises frames and queues
// the expected outcome; an independent monitor checks every output pulse.
module tb_uart_receiver;

  localparam int Cpb = 16;
  localparam int Lat = 2 + 1 + Cpb / 2 + 9 * Cpb;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] received_data;
  logic       data_ready;
  logic       framing_error;
  logic       busy;

  uart_receiver #(
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .serial_input_rx (rx),
    .received_data   (received_data),
    .data_ready      (data_ready),
    .framing_error   (framing_error),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       err;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on each pulse, checks pulse width afterwards.
  logic prev_pulse = 1'b0;
  exp_t mon_e;
  int   mon_diff;
  always @(negedge clk) begin
    if (reset) begin
      prev_pulse <= 1'b0;
    end else begin
      if (prev_pulse) begin
        check("pulse_width", {31'b0, data_ready | framing_error}, 32'd0);
      end else if (data_ready || framing_error) begin
        check("pulse_exclusive", {31'b0, data_ready & framing_error}, 32'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse cycle=%0d data_ready=%0b framing_error=%0b required=none",
                   cyc, data_ready, framing_error);
        end else begin
          mon_e = sb.pop_front();
          check("pulse_kind_ferr", {31'b0, framing_error}, {31'b0, mon_e.err});
          check("received_data", {24'b0, received_data}, {24'b0, mon_e.data});
          mon_diff = cyc - mon_e.due;
          checks++;
          if (mon_diff < -1 || mon_diff > 1) begin
            errors++;
            $display("FAIL pulse_latency actual_cycle=%0d required=%0d+-1", cyc, mon_e.due);
          end
        end
      end
      prev_pulse <= data_ready | framing_error;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    step(n);
  endtask

  // Serialise one full 8N1 frame; stop selects the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    exp_t e;
    bits   = {stop, b, 1'b0};
    e.err  = ~stop;
    e.data = stop ? b : model_data;
    e.due  = cyc + Lat;
    if (stop) model_data = b;
    sb.push_back(e);
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      if (i == 5) begin
        step(Cpb / 2);
        check("busy_mid_frame", {31'b0, busy}, 32'd1);
        step(Cpb / 2);
      end else begin
        step(Cpb);
      end
    end
    check("busy_after_stop", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic       rose;
    logic       fell;
    logic       last_stop;
    logic [7:0] rb;
    logic       rs;
    logic [7:0] mid;
    logic [9:0] mbits;

    reset = 1'b1;
    rx    = 1'b1;
    step(3);
    check("reset_data", {24'b0, received_data}, 32'h00);
    check("reset_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    step(50);
    check("idle_busy", {31'b0, busy}, 32'd0);
    check("idle_data_ready", {31'b0, data_ready}, 32'd0);
    check("idle_framing_error", {31'b0, framing_error}, 32'd0);
    check("idle_data", {24'b0, received_data}, 32'h00);

    send_frame(8'h5A, 1'b1);
    idle(20);

    // Short low glitch must abort at the mid-start sample.
    rose = 1'b0;
    fell = 1'b0;
    rx   = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (i == 3) rx = 1'b1;
      step(1);
      if (busy) rose = 1'b1;
      if (rose && !busy) fell = 1'b1;
    end
    check("glitch_busy_rise", {31'b0, rose}, 32'd1);
    check("glitch_busy_fall", {31'b0, fell}, 32'd1);
    idle(20);
    check("glitch_data_kept", {24'b0, received_data}, {24'b0, model_data});

    send_frame(8'hFF, 1'b0);
    idle(40);

    send_frame(8'h00, 1'b1);
    send_frame(8'hA5, 1'b1);
    idle(20);

    // Abort frame 0x3C in the middle of data bit 4.
    mid   = 8'h3C;
    mbits = {1'b1, mid, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx = mbits[i];
      step(Cpb);
    end
    rx = mbits[5];
    step(Cpb / 2);
    reset = 1'b1;
    rx    = 1'b1;
    step(3);
    model_data = 8'h00;
    check("midreset_data", {24'b0, received_data}, 32'h00);
    check("midreset_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    idle(20);
    check("postreset_data", {24'b0, received_data}, 32'h00);
    send_frame(8'h81, 1'b1);
    idle(20);

    // Random traffic, including back-to-back frames after good stop bits.
    last_stop = 1'b1;
    for (int n = 0; n < 24; n++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 4) != 0);
      if (!last_stop) idle(32 + $urandom_range(0, 20));
      else if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 40));
      send_frame(rb, rs);
      last_stop = rs;
    end
    idle(40);

    for (int i = 0; i < 300 && sb.size() != 0; i++) step(1);
    check("scoreboard_drained", sb.size(), 32'd0);
    check("final_data", {24'b0, received_data}, {24'b0, model_data});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
